// File: rtl/nbody_pkg.sv
// Shared select codes, field/state typedefs and field-to-select mapping for nbody_readback.
// NBODY_READBACK_VEL_EN adds VX/VY to each body's readback.
package nbody_pkg;

  typedef enum logic [6:0] {
    SelGo   = 7'h00,
    SelX    = 7'h03,
    SelY    = 7'h04,
    SelM    = 7'h05,
    SelVx   = 7'h06,
    SelVy   = 7'h07,
    SelDone = 7'h40
  } sel_e;

  typedef enum logic [1:0] {
    FieldX  = 2'd0,
    FieldY  = 2'd1,
    FieldVx = 2'd2,
    FieldVy = 2'd3
  } field_e;

  typedef enum logic [3:0] {
    StIdle,
    StGoWr,
    StPollRd,
    StPollCap,
    StPollGap,
    StFetchRd,
    StFetchCap,
    StEmit,
    StFinish
  } state_e;

  localparam int unsigned MaxBodies = 512;

`ifdef NBODY_READBACK_VEL_EN
  localparam field_e LastField = FieldVy;
`else
  localparam field_e LastField = FieldY;
`endif

  function automatic sel_e field_sel(field_e f);
    sel_e s;
    unique case (f)
      FieldX:  s = SelX;
      FieldY:  s = SelY;
      FieldVx: s = SelVx;
      FieldVy: s = SelVy;
      default: s = SelX;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nbody_readback_if.sv
// Memory-mapped bus and output stream of nbody_readback; master = the readback engine.
interface nbody_readback_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  m_chipselect;
  logic                  m_write;
  logic                  m_read;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [63:0]           m_writedata;
  logic [63:0]           m_readdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [63:0]           out_data;
  logic [8:0]            out_idx;
  logic [1:0]            out_field;

  modport master (
    output m_chipselect, m_write, m_read, m_addr, m_writedata,
    input  m_readdata,
    output out_valid, out_data, out_idx, out_field,
    input  out_ready
  );

  modport slave (
    input  m_chipselect, m_write, m_read, m_addr, m_writedata,
    output m_readdata,
    input  out_valid, out_data, out_idx, out_field,
    output out_ready
  );
endinterface

// File: rtl/nbody_readback.sv
// Kicks one simulation step, polls DONE, then streams back per-body state words.
// NBODY_READBACK_VEL_EN: stream X, Y, VX, VY per body instead of X, Y.
module nbody_readback
  import nbody_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned BODY_ADDR_WIDTH = 9,
  parameter int unsigned POLL_GAP        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [9:0]               n_bodies,
  nbody_readback_if.master         bus,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e           state_q, state_d;
  logic [9:0]       nb_q, nb_d;
  logic [9:0]       idx_q, idx_d;
  field_e           field_q, field_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [63:0]      data_q, data_d;
  logic             rd, wr;

  always_comb begin
    state_d          = state_q;
    nb_d             = nb_q;
    idx_d            = idx_q;
    field_d          = field_q;
    gap_d            = gap_q;
    data_d           = data_q;
    rd               = 1'b0;
    wr               = 1'b0;
    bus.m_addr       = '0;
    bus.m_writedata  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          nb_d    = (n_bodies > 10'(MaxBodies)) ? 10'(MaxBodies) : n_bodies;
          idx_d   = '0;
          field_d = FieldX;
          state_d = StGoWr;
        end
      end
      StGoWr: begin
        wr              = 1'b1;
        bus.m_addr      = ADDR_WIDTH'({SelGo, {BODY_ADDR_WIDTH{1'b0}}});
        bus.m_writedata = 64'd1;
        state_d         = StPollRd;
      end
      StPollRd: begin
        rd         = 1'b1;
        bus.m_addr = ADDR_WIDTH'({SelDone, {BODY_ADDR_WIDTH{1'b0}}});
        state_d    = StPollCap;
      end
      StPollCap: begin
        if (bus.m_readdata[0]) begin
          state_d = (nb_q == '0) ? StFinish : StFetchRd;
        end else begin
          gap_d   = GapW'(POLL_GAP - 1);
          state_d = StPollGap;
        end
      end
      StPollGap: begin
        if (gap_q == '0) state_d = StPollRd;
        else             gap_d   = gap_q - 1'b1;
      end
      StFetchRd: begin
        rd         = 1'b1;
        bus.m_addr = ADDR_WIDTH'({field_sel(field_q), idx_q[BODY_ADDR_WIDTH-1:0]});
        state_d    = StFetchCap;
      end
      StFetchCap: begin
        data_d  = bus.m_readdata;
        state_d = StEmit;
      end
      StEmit: begin
        // Nothing advances while the sink stalls, so no bus traffic either.
        if (bus.out_ready) begin
          if (field_q == LastField) begin
            field_d = FieldX;
            if (idx_q == nb_q - 10'd1) begin
              state_d = StFinish;
            end else begin
              idx_d   = idx_q + 10'd1;
              state_d = StFetchRd;
            end
          end else begin
            field_d = field_e'(field_q + 2'd1);
            state_d = StFetchRd;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    bus.m_read       = rd;
    bus.m_write      = wr;
    bus.m_chipselect = rd | wr;
    bus.out_valid    = (state_q == StEmit);
    bus.out_data     = bus.out_valid ? data_q : '0;
    bus.out_idx      = bus.out_valid ? idx_q[8:0] : '0;
    bus.out_field    = bus.out_valid ? field_q : FieldX;
    busy             = (state_q != StIdle) && (state_q != StFinish);
    done             = (state_q == StFinish);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      nb_q    <= '0;
      idx_q   <= '0;
      field_q <= FieldX;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      idx_q   <= idx_d;
      field_q <= field_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_nbody_readback.sv
// Scoreboard bench for nbody_readback: stimulus pushes expected bus ops and stream words,
// independent monitors pop and compare. Honours NBODY_READBACK_VEL_EN.
module tb_nbody_readback;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
  } bus_t;

  typedef struct {
    logic [63:0] data;
    logic [8:0]  idx;
    logic [1:0]  field;
  } word_t;

`ifdef NBODY_READBACK_VEL_EN
  localparam int NF = 4;
`else
  localparam int NF = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] n_bodies = '0;
  logic       busy, done;

  nbody_readback_if #(.ADDR_WIDTH(16)) bus ();

  nbody_readback #(
    .ADDR_WIDTH(16),
    .BODY_ADDR_WIDTH(9),
    .POLL_GAP(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .n_bodies(n_bodies),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  bus_t  exp_bus[$];
  word_t exp_words[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    done_cnt = 0;
  int    accepted = 0;
  int    polls_total = 0;
  int    poll_target = 1;
  bit    have_prev_poll = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    if (a == 16'h0600) return 64'h3FF0_0000_0000_0000;
    return {48'h4000_C0DE_0000, a};
  endfunction

  // Bus slave: read data appears the cycle after m_read; DONE reports 1 on the target poll.
  always @(posedge clk) begin
    if (bus.m_read) begin
      if (bus.m_addr == 16'h8000) begin
        polls_total     <= polls_total + 1;
        bus.m_readdata  <= (polls_total + 1 >= poll_target) ? 64'd1 : 64'd0;
      end else begin
        bus.m_readdata  <= mem_word(bus.m_addr);
      end
    end
  end

  // Bus monitor
  initial begin
    int cyc = 0;
    int last_poll = 0;
    bus_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.m_read || bus.m_write) begin
        check(!(bus.m_read && bus.m_write), "rw_exclusive", {bus.m_read, bus.m_write}, 0);
        check(bus.m_chipselect == 1'b1, "chipselect", bus.m_chipselect, 1);
        if (exp_bus.size() == 0) begin
          check(1'b0, "bus_extra_op", bus.m_addr, 0);
        end else begin
          e = exp_bus.pop_front();
          check(bus.m_addr == e.addr, "bus_addr", bus.m_addr, e.addr);
          check(bus.m_write == e.wr, "bus_kind", bus.m_write, e.wr);
          if (bus.m_write) check(bus.m_writedata == 64'd1, "go_data", bus.m_writedata, 1);
        end
        if (bus.m_read && bus.m_addr == 16'h8000) begin
          if (have_prev_poll) check(cyc - last_poll >= 9, "poll_gap", cyc - last_poll, 9);
          last_poll      = cyc;
          have_prev_poll = 1;
        end
      end
    end
  end

  // Stream monitor
  initial begin
    bit          stall_prev = 0;
    logic [63:0] h_data;
    logic [8:0]  h_idx;
    logic [1:0]  h_field;
    word_t       w;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
`ifndef NBODY_READBACK_VEL_EN
      if (bus.out_valid) check(bus.out_field <= 2'd1, "field_range", bus.out_field, 1);
`endif
      if (bus.out_valid && bus.out_ready) begin
        accepted++;
        if (exp_words.size() == 0) begin
          check(1'b0, "word_extra", bus.out_data, 0);
        end else begin
          w = exp_words.pop_front();
          check(bus.out_data == w.data, "word_data", bus.out_data, w.data);
          check(bus.out_idx == w.idx, "word_idx", bus.out_idx, w.idx);
          check(bus.out_field == w.field, "word_field", bus.out_field, w.field);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        check(!bus.m_read, "read_in_stall", bus.m_read, 0);
        if (stall_prev) begin
          check(bus.out_data == h_data, "stall_data", bus.out_data, h_data);
          check(bus.out_idx == h_idx, "stall_idx", bus.out_idx, h_idx);
          check(bus.out_field == h_field, "stall_field", bus.out_field, h_field);
        end
        h_data = bus.out_data; h_idx = bus.out_idx; h_field = bus.out_field;
        stall_prev = 1;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_start(input int n, input int polls);
    int nb;
    int sel_tab[4] = '{3, 4, 6, 7};
    logic [15:0] a;
    bus_t b;
    word_t w;
    poll_target    = polls_total + polls;
    have_prev_poll = 0;
    b.wr = 1'b1; b.addr = 16'h0000; exp_bus.push_back(b);
    for (int i = 0; i < polls; i++) begin
      b.wr = 1'b0; b.addr = 16'h8000; exp_bus.push_back(b);
    end
    nb = (n > 512) ? 512 : n;
    for (int i = 0; i < nb; i++) begin
      for (int f = 0; f < NF; f++) begin
        a = 16'((sel_tab[f] << 9) | i);
        b.wr = 1'b0; b.addr = a; exp_bus.push_back(b);
        w.data = mem_word(a); w.idx = 9'(i); w.field = 2'(f);
        exp_words.push_back(w);
      end
    end
    start = 1'b1; n_bodies = 10'(n);
    step();
    start = 1'b0;
    step();
    check(busy == 1'b1, "busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int c0 = done_cnt;
    int n = 0;
    while (done_cnt == c0 && n < budget) begin
      step();
      n++;
    end
    check(done_cnt != c0, {name, "_timeout"}, n, budget);
    repeat (3) step();
    check(done_cnt == c0 + 1, {name, "_done_once"}, done_cnt - c0, 1);
    check(!busy, {name, "_idle_busy"}, busy, 0);
    check(exp_bus.size() == 0, {name, "_bus_left"}, exp_bus.size(), 0);
    check(exp_words.size() == 0, {name, "_words_left"}, exp_words.size(), 0);
    exp_bus.delete();
    exp_words.delete();
  endtask

  initial begin
    int n;
    bus.out_ready = 1'b1;
    #1;
    check(busy == 0 && done == 0, "rst_status", {busy, done}, 0);
    check(bus.m_chipselect == 0 && bus.m_read == 0 && bus.m_write == 0, "rst_bus",
          {bus.m_chipselect, bus.m_read, bus.m_write}, 0);
    check(bus.m_addr == 0, "rst_addr", bus.m_addr, 0);
    check(bus.out_valid == 0 && bus.out_data == 0, "rst_out", bus.out_data, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Three bodies, DONE reads 0,0,0,1, sink stalls 20 cycles on word 1, extra start ignored.
    run_start(3, 4);
    repeat (3) step();
    start = 1'b1; n_bodies = 10'd5;
    step();
    start = 1'b0;
    n = 0;
    while (!(accepted == 1 && bus.out_valid) && n < 300) begin
      step();
      n++;
    end
    check(n < 300, "stall_reached", n, 300);
    bus.out_ready = 1'b0;
    repeat (20) step();
    bus.out_ready = 1'b1;
    wait_done(500, "run3");

    // Zero bodies: GO plus one poll, no fetches.
    run_start(0, 1);
    wait_done(200, "run0");

    // Reset during FETCH_CAP of body 1, then a clean rerun.
    run_start(3, 1);
    n = 0;
    while (!(bus.m_read && bus.m_addr == 16'h0601) && n < 300) begin
      step();
      n++;
    end
    check(n < 300, "fetch1_seen", n, 300);
    step();
    rst_n = 1'b0;
    #1;
    check(bus.out_valid == 0 && bus.out_data == 0 && bus.out_idx == 0 && bus.out_field == 0,
          "rst_mid_out", bus.out_data, 0);
    check(bus.m_chipselect == 0 && bus.m_read == 0 && bus.m_write == 0 && bus.m_addr == 0,
          "rst_mid_bus", bus.m_addr, 0);
    check(busy == 0 && done == 0, "rst_mid_status", {busy, done}, 0);
    check(exp_words.size() == 2 * NF, "rst_words_left", exp_words.size(), 2 * NF);
    check(exp_bus.size() == 2 * NF - 1, "rst_bus_left", exp_bus.size(), 2 * NF - 1);
    exp_bus.delete();
    exp_words.delete();
    step();
    rst_n = 1'b1;
    step();
    run_start(2, 1);
    wait_done(300, "rerun2");

    // Oversized body count clamps to 512 without index wrap.
    run_start(600, 2);
    wait_done(12000, "clamp");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nbody_readback.md
NBODY_READBACK -- requirements
Module: nbody_readback

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 16, bus address width; BODY_ADDR_WIDTH, 9, body-index field width; POLL_GAP, 8, idle cycles between DONE polls.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  single-cycle request to run one step and read back
- n_bodies  in  10  body count, sampled on accepted start
- m_chipselect  out  1  bus select
- m_write  out  1  bus write strobe
- m_read  out  1  bus read strobe
- m_addr  out  ADDR_WIDTH  {select[6:0], index[BODY_ADDR_WIDTH-1:0]}
- m_writedata  out  64  write data
- m_readdata  in  64  read data, valid exactly 1 cycle after m_read
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_data  out  64  IEEE-754 double
- out_idx  out  9  body index
- out_field  out  2  0=X, 1=Y, 2=VX, 3=VY
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted

Function
REQ-004 Select codes SHALL be GO=7'h00, X=7'h03, Y=7'h04, M=7'h05, VX=7'h06, VY=7'h07, DONE=7'h40.
REQ-005 The FSM SHALL have states IDLE, GO_WR, POLL_RD, POLL_CAP, POLL_GAP, FETCH_RD, FETCH_CAP, EMIT, FINISH.
REQ-006 IDLE -> GO_WR on start; start while busy SHALL be ignored.
REQ-007 GO_WR SHALL drive chipselect=1, write=1, addr=0x0000, writedata=1 for exactly one cycle, then go to POLL_RD.
REQ-008 POLL_RD SHALL drive chipselect=1, read=1, addr=0x8000 for one cycle; POLL_CAP SHALL sample m_readdata[0].
REQ-009 readdata[0]=1 -> FETCH_RD (or FINISH if n_bodies=0); else -> POLL_GAP for POLL_GAP cycles, then POLL_RD.
REQ-010 FETCH_RD SHALL issue one read at {field select, idx}; FETCH_CAP SHALL latch m_readdata into out_data and enter EMIT.
REQ-011 EMIT SHALL hold out_valid and all out_* stable until out_ready=1; no bus read SHALL be issued while out_valid && !out_ready.
REQ-012 Order SHALL be body-major, field-minor: idx 0 X, idx 0 Y, idx 1 X, ...; after the last word of the last body -> FINISH.
REQ-013 FINISH SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-014 n_bodies > 512 SHALL be clamped to 512; idx SHALL never wrap.
REQ-015 m_chipselect SHALL equal m_read | m_write; m_read and m_write SHALL never be high together.
REQ-016 Minimum cost per word is 3 cycles (RD, CAP, EMIT with out_ready=1).

Reset
REQ-017 rst_n low SHALL force IDLE and zero all outputs, counters and latched n_bodies, including mid-poll or mid-EMIT; no partial word SHALL survive.

Configuration
REQ-018 NBODY_READBACK_VEL_EN defined: each body SHALL yield 4 words, X, Y, VX, VY. Undefined: 2 words, X, Y; out_field SHALL stay 0/1.

Structure
REQ-019 Select codes, field enum and state typedef SHALL live in shared package nbody_pkg; no sub-module is required.

Verification
REQ-020 Reset, start, n_bodies=3, DONE reads 0,0,0,1 -> one GO write to 0x0000, four reads of 0x8000 each spaced by ≥8 idle cycles, then reads 0x0600,0x0800,0x0601,...,0x0802.
REQ-021 Body 0 X=0x3FF0000000000000 (1.0) -> first word out_data=0x3FF0000000000000, idx=0, field=0.
REQ-022 out_ready held 0 for 20 cycles on word 2 -> word stable, no bus reads during the stall, sequence resumes intact.
REQ-023 n_bodies=0 -> GO and DONE poll only, no fetch reads, done pulses once.
REQ-024 rst_n asserted during FETCH_CAP of body 1 -> all outputs 0 next cycle; a new start runs the full sequence from idx 0.
REQ-025 With NBODY_READBACK_VEL_EN, n_bodies=2 -> 8 words; addresses include 0x0C00, 0x0E00, 0x0C01, 0x0E01.
